// File: rtl/spu_reverb_mac_engine.sv
// Microcoded reverb multiply-accumulate engine: runs a loadable program once
// per channel per sample tick, with saturating accumulation and req/ack
// reverb-ring memory access.
module spu_reverb_mac_engine #(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 18,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned PROG_DEPTH = 64
) (
    input  logic                          i_clk,
    input  logic                          i_nrst,
    input  logic                          i_start,
    input  logic                          i_enable,
    input  logic                          i_progWe,
    input  logic [$clog2(PROG_DEPTH)-1:0] i_progAdr,
    input  logic [15:0]                   i_progData,
    input  logic [15:0]                   i_base,
    input  logic [AW-1:0]                 i_counter,
    output logic [4:0]                    o_coefIdx,
    input  logic [DW-1:0]                 i_coef,
    output logic [4:0]                    o_adrIdx,
    input  logic [15:0]                   i_adrOfs,
    input  logic [CHANNELS*DW-1:0]        i_lineIn,
    output logic                          o_memReq,
    output logic                          o_memWr,
    output logic [AW-1:0]                 o_memAdr,
    output logic [DW-1:0]                 o_memWData,
    input  logic                          i_memAck,
    input  logic [DW-1:0]                 i_memRData,
    output logic [CHANNELS*DW-1:0]        o_out,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_overrun
);

    localparam int unsigned PW = $clog2(PROG_DEPTH);
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
    localparam logic [AW:0]   ADR_SPAN = {1'b1, {AW{1'b0}}};

    localparam logic [2:0] OP_MAC_IN  = 3'd1;
    localparam logic [2:0] OP_MAC_RAM = 3'd2;
    localparam logic [2:0] OP_MAC_ACC = 3'd3;
    localparam logic [2:0] OP_WRITE   = 3'd4;
    localparam logic [2:0] OP_OUT     = 3'd5;
    localparam logic [2:0] OP_END     = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          pc_q, pc_d;
    logic [CW-1:0]          ch_q, ch_d;
    logic [DW-1:0]          acc_q, acc_d;
    logic [CHANNELS*DW-1:0] out_q, out_d;
    logic                   req_q, req_d;
    logic                   wr_q, wr_d;
    logic [AW-1:0]          adr_q, adr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic [15:0]            instr_q;
    logic [15:0]            prog_mem [PROG_DEPTH];

    logic [2:0]    op_c;
    logic          m1_c, acc_en_c, chsel_c;
    logic [DW-1:0] coef_val_c;
    logic [DW-1:0] line_b_c;
    logic [AW-1:0] base_w_c, ofs_w_c, rel_raw_c, rel_c, mem_adr_c;
    logic [AW:0]   ring_size_c;
    logic          step_c, fin_c;

    // Saturating Q1.(DW-1) multiply-accumulate.
    function automatic logic [DW-1:0] mac_f(input logic [DW-1:0] coef,
                                            input logic [DW-1:0] b,
                                            input logic [DW-1:0] a,
                                            input logic          use_acc);
        logic signed [2*DW-1:0] prod;
        logic signed [2*DW-1:0] shf;
        logic [DW-1:0]          p;
        logic [DW-1:0]          a_in;
        logic [DW:0]            sum;
        prod = (2*DW)'($signed(coef)) * (2*DW)'($signed(b));
        shf  = prod >>> (DW-1);
        if (shf[2*DW-1:DW-1] != {(DW+1){shf[2*DW-1]}}) begin
            p = shf[2*DW-1] ? MINV : MAXV;
        end else begin
            p = shf[DW-1:0];
        end
        a_in = use_acc ? a : '0;
        sum  = {a_in[DW-1], a_in} + {p[DW-1], p};
        if (sum[DW] != sum[DW-1]) begin
            return sum[DW] ? MINV : MAXV;
        end
        return sum[DW-1:0];
    endfunction

    // Instruction field decode and register-file lookups.
    assign op_c      = instr_q[15:13];
    assign m1_c      = instr_q[2];
    assign acc_en_c  = instr_q[1];
    assign chsel_c   = instr_q[0];
    assign o_coefIdx = instr_q[12:8];
    assign o_adrIdx  = instr_q[7:3] + (chsel_c ? 5'(ch_q) : 5'd0);

    // Constant coefficients for +1 / -1, otherwise the register file value.
    always_comb begin
        case (instr_q[12:8])
            5'd30:   coef_val_c = MAXV;
            5'd31:   coef_val_c = MINV;
            default: coef_val_c = i_coef;
        endcase
    end

    // Line input of the channel being processed.
    always_comb begin
        line_b_c = i_lineIn[ch_q*DW +: DW];
    end

    // Reverb-ring address: offset from current position, folded once into the ring.
    assign base_w_c    = AW'({i_base, 2'b00});
    assign ofs_w_c     = AW'({i_adrOfs, 2'b00});
    assign rel_raw_c   = i_counter + ofs_w_c - AW'(m1_c);
    assign ring_size_c = ADR_SPAN - {1'b0, base_w_c};
    assign rel_c       = ({1'b0, rel_raw_c} >= ring_size_c) ? (rel_raw_c - ring_size_c[AW-1:0])
                                                            : rel_raw_c;
    assign mem_adr_c   = base_w_c + rel_c;

    // Program store; writable only while idle.
    always_ff @(posedge i_clk) begin
        if ((state_q == S_IDLE) && i_progWe) begin
            prog_mem[i_progAdr] <= i_progData;
        end
    end

    // Registered program read during FETCH.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            instr_q <= '0;
        end else if (state_q == S_FETCH) begin
            instr_q <= prog_mem[pc_q];
        end
    end

    // Next-state, sequencing and datapath updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ch_d      = ch_q;
        acc_d     = acc_q;
        out_d     = out_q;
        req_d     = req_q;
        wr_d      = wr_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = i_start && (state_q != S_IDLE);
        step_c    = 1'b0;
        fin_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_c)
                    OP_MAC_IN: begin
                        acc_d  = mac_f(coef_val_c, line_b_c, acc_q, acc_en_c);
                        step_c = 1'b1;
                    end
                    OP_MAC_ACC: begin
                        acc_d  = mac_f(coef_val_c, acc_q, acc_q, acc_en_c);
                        step_c = 1'b1;
                    end
                    OP_OUT: begin
                        out_d[ch_q*DW +: DW] = acc_q;
                        step_c = 1'b1;
                    end
                    OP_MAC_RAM: begin
                        req_d   = 1'b1;
                        wr_d    = 1'b0;
                        adr_d   = mem_adr_c;
                        state_d = S_MEM;
                    end
                    OP_WRITE: begin
                        if (i_enable) begin
                            req_d   = 1'b1;
                            wr_d    = 1'b1;
                            adr_d   = mem_adr_c;
                            wdata_d = acc_q;
                            state_d = S_MEM;
                        end else begin
                            step_c = 1'b1;
                        end
                    end
                    OP_END: begin
                        fin_c = 1'b1;
                    end
                    default: begin
                        step_c = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (i_memAck) begin
                    req_d = 1'b0;
                    if (!wr_q) begin
                        acc_d = mac_f(coef_val_c, i_memRData, acc_q, acc_en_c);
                    end
                    step_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (step_c && (pc_q != PW'(PROG_DEPTH-1))) begin
            pc_d    = pc_q + PW'(1);
            state_d = S_FETCH;
        end else if (step_c || fin_c) begin
            pc_d = '0;
            if (ch_q == CW'(CHANNELS-1)) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                ch_d    = ch_q + CW'(1);
                state_d = S_FETCH;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            pc_q      <= '0;
            ch_q      <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            adr_q     <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ch_q      <= ch_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            req_q     <= req_d;
            wr_q      <= wr_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_memReq   = req_q;
    assign o_memWr    = wr_q;
    assign o_memAdr   = adr_q;
    assign o_memWData = wdata_q;
    assign o_out      = out_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_spu_reverb_mac_engine.sv
// Bench for spu_reverb_mac_engine: an instruction-level interpreter predicts
// outputs, memory transactions and run length for each program.
module tb_spu_reverb_mac_engine;

    localparam int DW = 16;
    localparam int AW = 18;
    localparam int CH = 2;
    localparam int PD = 64;

    logic           i_clk = 1'b0;
    logic           i_nrst, i_start, i_enable, i_progWe;
    logic [5:0]     i_progAdr;
    logic [15:0]    i_progData, i_base;
    logic [AW-1:0]  i_counter;
    logic [4:0]     o_coefIdx, o_adrIdx;
    logic [DW-1:0]  i_coef;
    logic [15:0]    i_adrOfs;
    logic [CH*DW-1:0] i_lineIn;
    logic           o_memReq, o_memWr;
    logic [AW-1:0]  o_memAdr;
    logic [DW-1:0]  o_memWData;
    logic           i_memAck;
    logic [DW-1:0]  i_memRData;
    logic [CH*DW-1:0] o_out;
    logic           o_busy, o_done, o_overrun;

    logic [15:0] coef_tab [32];
    logic [15:0] ofs_tab  [32];
    logic [15:0] prog     [PD];
    int          dly      [256];

    typedef struct {
        bit wr;
        int adr;
        int data;
    } txn_t;

    txn_t got_q[$];
    txn_t exp_q[$];
    txn_t rt;
    int   checks = 0;
    int   errors = 0;
    int   m_acc;
    int   m_out [CH];
    int   exp_cycles;
    int   resp_idx;
    int   rd;
    bit   resp_en;

    always #5 i_clk = ~i_clk;

    assign i_coef   = coef_tab[o_coefIdx];
    assign i_adrOfs = ofs_tab[o_adrIdx];

    spu_reverb_mac_engine dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_enable(i_enable),
        .i_progWe(i_progWe), .i_progAdr(i_progAdr), .i_progData(i_progData),
        .i_base(i_base), .i_counter(i_counter), .o_coefIdx(o_coefIdx), .i_coef(i_coef),
        .o_adrIdx(o_adrIdx), .i_adrOfs(i_adrOfs), .i_lineIn(i_lineIn),
        .o_memReq(o_memReq), .o_memWr(o_memWr), .o_memAdr(o_memAdr),
        .o_memWData(o_memWData), .i_memAck(i_memAck), .i_memRData(i_memRData),
        .o_out(o_out), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
    );

    // ---------------- reference model ----------------
    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int mac_m(input int c, input int b, input int a, input bit use_acc);
        int p;
        p = sat((c * b) >>> 15);
        return sat((use_acc ? a : 0) + p);
    endfunction

    function automatic logic [15:0] rd_hash(input int adr);
        return 16'((adr * 40503) ^ (adr >> 5));
    endfunction

    function automatic int coef_of(input int idx);
        if (idx == 30) return 32767;
        if (idx == 31) return -32768;
        return sx(coef_tab[idx]);
    endfunction

    function automatic int addr_of(input int ofs_idx, input bit m1);
        int rel, sz, b4;
        b4  = int'(i_base) * 4;
        rel = (int'(i_counter) + int'(ofs_tab[ofs_idx]) * 4 - int'(m1)) & 32'h3FFFF;
        sz  = 262144 - b4;
        if (rel >= sz) rel = rel - sz;
        return (b4 + rel) & 32'h3FFFF;
    endfunction

    function automatic logic [15:0] ins(input int op, input int cf, input int ad,
                                        input bit m1, input bit ac, input bit cs);
        return {3'(op), 5'(cf), 5'(ad), m1, ac, cs};
    endfunction

    // Interpret the program over all channels from the current model state.
    task automatic model_run(input bit en);
        int pc, k, op, cidx, aidx, a;
        bit fin;
        logic [15:0] w;
        logic [CH*DW-1:0] li;
        li = i_lineIn;
        exp_q.delete();
        exp_cycles = 0;
        k = 0;
        for (int ch = 0; ch < CH; ch++) begin
            pc  = 0;
            fin = 0;
            while (!fin) begin
                w    = prog[pc];
                op   = int'(w[15:13]);
                cidx = int'(w[12:8]);
                aidx = (int'(w[7:3]) + (w[0] ? ch : 0)) % 32;
                exp_cycles += 2;
                case (op)
                    1: m_acc = mac_m(coef_of(cidx), sx(li[ch*16 +: 16]), m_acc, w[1]);
                    2: begin
                        a = addr_of(aidx, w[2]);
                        exp_q.push_back('{1'b0, a, 0});
                        exp_cycles += dly[k] + 1;
                        k++;
                        m_acc = mac_m(coef_of(cidx), sx(rd_hash(a)), m_acc, w[1]);
                    end
                    3: m_acc = mac_m(coef_of(cidx), m_acc, m_acc, w[1]);
                    4: if (en) begin
                        a = addr_of(aidx, w[2]);
                        exp_q.push_back('{1'b1, a, m_acc & 32'hFFFF});
                        exp_cycles += dly[k] + 1;
                        k++;
                    end
                    5: m_out[ch] = m_acc;
                    6: fin = 1;
                    default: ;
                endcase
                if (op != 6) begin
                    pc++;
                    if (pc == PD) fin = 1;
                end
            end
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        i_memAck   = 1'b0;
        i_memRData = '0;
        forever begin
            @(negedge i_clk);
            if (resp_en) begin
                if (i_memAck) begin
                    i_memAck = 1'b0;
                end else if (o_memReq) begin
                    rt.wr   = o_memWr;
                    rt.adr  = int'(o_memAdr);
                    rt.data = int'(o_memWData);
                    got_q.push_back(rt);
                    rd = dly[resp_idx & 255];
                    resp_idx++;
                    for (int i = 0; i < rd; i++) begin
                        @(negedge i_clk);
                        checks++;
                        if (o_memReq !== 1'b1 || o_memWr !== rt.wr || int'(o_memAdr) !== rt.adr
                            || int'(o_memWData) !== rt.data) begin
                            errors++;
                            $display("FAIL req_stable got req=%0b wr=%0b adr=%0h exp wr=%0b adr=%0h",
                                     o_memReq, o_memWr, o_memAdr, rt.wr, rt.adr);
                        end
                    end
                    i_memAck   = 1'b1;
                    i_memRData = rd_hash(rt.adr);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic load_prog(input bit stale0);
        for (int i = 0; i < PD; i++) begin
            @(negedge i_clk);
            i_progWe   = 1'b1;
            i_progAdr  = 6'(i);
            i_progData = (stale0 && i == 0) ? 16'hC000 : prog[i];
        end
        @(negedge i_clk);
        i_progWe = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < PD; i++) prog[i] = 16'h0000;
    endtask

    // Start a run, optionally poke i_start mid-run, compare with the model.
    task automatic run_prog(input bit en, input int ovr_at, input bit we0, output int n);
        int ovr, dcount;
        logic [CH*DW-1:0] ov;
        i_enable = en;
        for (int i = 0; i < CH; i++) ;
        model_run(en);
        ovr = (ovr_at == -2) ? exp_cycles / 2 : ovr_at;
        got_q.delete();
        resp_idx = 0;
        n = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        if (we0) begin
            i_progWe   = 1'b1;
            i_progAdr  = 6'd0;
            i_progData = prog[0];
        end
        @(posedge i_clk);
        #1;
        i_start  = 1'b0;
        i_progWe = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            if (c - 1 == ovr) i_start = 1'b1;
            @(posedge i_clk);
            #1;
            if (c == 1) begin
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_start got %0b exp 1", o_busy);
                end
            end
            if (c - 1 == ovr) begin
                i_start = 1'b0;
                checks++;
                if (o_overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun got %0b exp 1", o_overrun);
                end
            end
            if (o_done === 1'b1) begin
                n = c;
                break;
            end
        end
        checks++;
        if (n != exp_cycles) begin
            errors++;
            $display("FAIL run_cycles got %0d exp %0d", n, exp_cycles);
        end
        dcount = 0;
        repeat (4) begin
            @(posedge i_clk);
            #1;
            if (o_done === 1'b1) dcount++;
        end
        checks++;
        if (dcount != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_once got extra=%0d busy=%0b exp 0 0", dcount, o_busy);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL txn_count got %0d exp %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i].wr != exp_q[i].wr || got_q[i].adr != exp_q[i].adr
                    || (exp_q[i].wr && got_q[i].data != exp_q[i].data)) begin
                    errors++;
                    $display("FAIL txn%0d got wr=%0b adr=%0h d=%0h exp wr=%0b adr=%0h d=%0h", i,
                             got_q[i].wr, got_q[i].adr, got_q[i].data,
                             exp_q[i].wr, exp_q[i].adr, exp_q[i].data);
                end
            end
        end
        ov = o_out;
        for (int ch = 0; ch < CH; ch++) begin
            checks++;
            if (ov[ch*16 +: 16] !== 16'(m_out[ch])) begin
                errors++;
                $display("FAIL out_ch%0d got %0h exp %0h", ch, ov[ch*16 +: 16], 16'(m_out[ch]));
            end
        end
    endtask

    task automatic rand_tables();
        for (int i = 0; i < 32; i++) begin
            coef_tab[i] = 16'($urandom);
            ofs_tab[i]  = 16'($urandom);
        end
        for (int i = 0; i < 256; i++) dly[i] = $urandom_range(0, 7);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_nrst = 1'b0; i_start = 1'b0; i_enable = 1'b1; i_progWe = 1'b0;
        i_progAdr = '0; i_progData = '0; i_base = '0; i_counter = '0; i_lineIn = '0;
        resp_en = 1'b1; resp_idx = 0;
        for (int i = 0; i < 32; i++) begin coef_tab[i] = '0; ofs_tab[i] = '0; end
        for (int i = 0; i < 256; i++) dly[i] = 0;
        m_acc = 0;
        for (int i = 0; i < CH; i++) m_out[i] = 0;
        repeat (3) @(negedge i_clk);
        i_nrst = 1'b1;
        @(negedge i_clk);
        checks++; if (o_memReq !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", o_memReq); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", o_done); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %0b exp 0", o_overrun); end
        checks++; if (o_out !== '0) begin errors++; $display("FAIL rst_out got %0h exp 0", o_out); end
        checks++; if (o_memAdr !== '0 || o_memWr !== 1'b0 || o_memWData !== '0) begin
            errors++; $display("FAIL rst_mem got adr=%0h wr=%0b wd=%0h exp 0", o_memAdr, o_memWr, o_memWData);
        end
        checks++; if (o_coefIdx !== 5'd0 || o_adrIdx !== 5'd0) begin
            errors++; $display("FAIL rst_idx got %0h %0h exp 0 0", o_coefIdx, o_adrIdx);
        end
    endtask

    task automatic test_basic();
        int n;
        clear_prog();
        prog[0] = ins(1, 30, 0, 0, 0, 0);
        prog[1] = ins(5, 0, 0, 0, 0, 0);
        prog[2] = ins(6, 0, 0, 0, 0, 0);
        i_lineIn = {16'($urandom), 16'h4000};
        load_prog(1'b0);
        run_prog(1'b1, -1, 1'b0, n);
        checks++; if (o_out[15:0] !== 16'h3FFF) begin errors++; $display("FAIL basic_out0 got %0h exp 3fff", o_out[15:0]); end
        checks++; if (n != 6 * CH) begin errors++; $display("FAIL basic_latency got %0d exp %0d", n, 6 * CH); end
    endtask

    task automatic test_saturation();
        int n;
        clear_prog();
        prog[0] = ins(1, 30, 0, 0, 0, 0);
        prog[1] = ins(3, 30, 0, 0, 1, 0);
        prog[2] = ins(5, 0, 0, 0, 0, 0);
        prog[3] = ins(6, 0, 0, 0, 0, 0);
        i_lineIn = {16'h8000, 16'h7001};
        load_prog(1'b0);
        run_prog(1'b1, -1, 1'b0, n);
        checks++; if (o_out !== {16'h8000, 16'h7FFF}) begin errors++; $display("FAIL sat_pos_neg got %0h exp 80007fff", o_out); end
        clear_prog();
        prog[0] = ins(1, 31, 0, 0, 0, 0);
        prog[1] = ins(5, 0, 0, 0, 0, 0);
        prog[2] = ins(6, 0, 0, 0, 0, 0);
        i_lineIn = {16'h8000, 16'h8000};
        load_prog(1'b0);
        run_prog(1'b1, -1, 1'b0, n);
        checks++; if (o_out !== {16'h7FFF, 16'h7FFF}) begin errors++; $display("FAIL sat_m1xm1 got %0h exp 7fff7fff", o_out); end
    endtask

    task automatic test_ring_wrap();
        int n;
        rand_tables();
        for (int i = 0; i < 256; i++) dly[i] = 0;
        ofs_tab[4] = 16'd2;
        ofs_tab[9] = 16'd3;
        i_base = 16'hFFF0;
        i_counter = 18'h38;
        clear_prog();
        prog[0] = ins(2, 5, 4, 1, 0, 0);
        prog[1] = ins(4, 0, 9, 0, 0, 0);
        prog[2] = ins(5, 0, 0, 0, 0, 0);
        prog[3] = ins(6, 0, 0, 0, 0, 0);
        load_prog(1'b0);
        run_prog(1'b1, -1, 1'b0, n);
        checks++;
        if (got_q.size() < 2) begin
            errors++; $display("FAIL wrap_count got %0d exp 4", got_q.size());
        end else if (got_q[0].adr != 32'h3FFFF || got_q[1].adr != 32'h3FFC4) begin
            errors++; $display("FAIL wrap_adr got %0h %0h exp 3ffff 3ffc4", got_q[0].adr, got_q[1].adr);
        end
    endtask

    task automatic test_random();
        int n, len;
        for (int it = 0; it < 6; it++) begin
            rand_tables();
            i_base    = 16'($urandom);
            i_counter = 18'($urandom);
            i_lineIn  = 32'($urandom);
            clear_prog();
            len = (it == 5) ? PD : $urandom_range(4, 20);
            for (int i = 0; i < len; i++) begin
                int op;
                op = $urandom_range(0, 7);
                if (op == 6) op = 1;
                prog[i] = ins(op, $urandom_range(0, 31), $urandom_range(0, 31),
                              1'($urandom), 1'($urandom), 1'($urandom));
            end
            if (it != 5) prog[len-1] = ins(6, 0, 0, 0, 0, 0);
            load_prog(it == 2);
            run_prog(it != 3, -1, it == 2, n);
        end
    endtask

    task automatic test_enable();
        int n;
        rand_tables();
        clear_prog();
        prog[0] = ins(1, 30, 0, 0, 0, 0);
        prog[1] = ins(4, 0, 3, 0, 0, 1);
        prog[2] = ins(5, 0, 0, 0, 0, 0);
        prog[3] = ins(6, 0, 0, 0, 0, 0);
        i_lineIn = 32'($urandom);
        load_prog(1'b0);
        run_prog(1'b0, -1, 1'b0, n);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL en0_req got %0d exp 0", got_q.size()); end
        checks++; if (n != 8 * CH) begin errors++; $display("FAIL en0_latency got %0d exp %0d", n, 8 * CH); end
    endtask

    task automatic test_overrun();
        int n;
        rand_tables();
        clear_prog();
        for (int i = 0; i < 9; i++)
            prog[i] = ins($urandom_range(1, 5), $urandom_range(0, 31), $urandom_range(0, 31),
                          1'($urandom), 1'($urandom), 1'($urandom));
        prog[9] = ins(6, 0, 0, 0, 0, 0);
        i_lineIn = 32'($urandom);
        load_prog(1'b0);
        run_prog(1'b1, -2, 1'b0, n);
    endtask

    task automatic test_mem_reset();
        int n, seen;
        clear_prog();
        prog[0] = ins(2, 1, 2, 0, 0, 0);
        prog[1] = ins(6, 0, 0, 0, 0, 0);
        load_prog(1'b0);
        resp_en = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge i_clk);
            #1;
            if (o_memReq === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mrst_req_seen got 0 exp 1"); end
        #2;
        i_nrst = 1'b0;
        #1;
        checks++; if (o_memReq !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL mrst_drop got req=%0b busy=%0b exp 0 0", o_memReq, o_busy);
        end
        @(negedge i_clk);
        i_nrst = 1'b1;
        m_acc = 0;
        for (int i = 0; i < CH; i++) m_out[i] = 0;
        @(posedge i_clk);
        #1 i_memAck = 1'b1;
        @(posedge i_clk);
        #1 i_memAck = 1'b0;
        checks++; if (o_busy !== 1'b0 || o_memReq !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL idle_ack got busy=%0b req=%0b done=%0b exp 0 0 0", o_busy, o_memReq, o_done);
        end
        resp_en = 1'b1;
        clear_prog();
        prog[0] = ins(1, 30, 0, 0, 0, 0);
        prog[1] = ins(5, 0, 0, 0, 0, 0);
        prog[2] = ins(6, 0, 0, 0, 0, 0);
        i_lineIn = {16'h1234, 16'h4000};
        load_prog(1'b0);
        run_prog(1'b1, -1, 1'b0, n);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_ring_wrap();
        test_enable();
        test_overrun();
        test_random();
        test_mem_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
